// File: rtl/plab5_mcore_net_msg_to_mem_resp.sv
// Core-side receive adapter: network response message -> memory response, 2-entry FIFO.
// Latency: 1 cycle minimum from net handshake to mem_resp_val; no combinational bypass.
// Backpressure: net_rdy low when full, in reset, or in a domain-switch (flush) cycle.
// Optional: PLAB5_MCORE_NET_RESP_VIOL_CNT_EN builds a saturating dropped-packet counter.
module plab5_mcore_net_msg_to_mem_resp #(
  parameter int p_net_dest          = 0,
  parameter int p_num_ports         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  localparam int c_mc = 3 + p_mem_opaque_nbits + 2,
  localparam int c_cn = 2*p_net_srcdest_nbits + p_net_opaque_nbits + c_mc + 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        domain,
  input  logic [c_cn-1:0]             net_msg_control,
  input  logic [p_mem_data_nbits-1:0] net_msg_data,
  input  logic                        net_val,
  output logic                        net_rdy,
  output logic [c_mc-1:0]             mem_resp_control,
  output logic [p_mem_data_nbits-1:0] mem_resp_data,
  output logic                        mem_resp_fail,
  output logic                        mem_resp_val,
  input  logic                        mem_resp_rdy,
  output logic [7:0]                  viol_count
);

  localparam int c_ns = p_net_srcdest_nbits;
  localparam int c_no = p_net_opaque_nbits;
  localparam logic [c_ns-1:0] c_dest = c_ns'(p_net_dest);

  // A port id outside the network is a configuration error.
  if (p_net_dest >= p_num_ports) begin : g_bad_dest
    $error("p_net_dest must be below p_num_ports");
  end

  // Packet field views
  logic [c_ns-1:0] pkt_dest;
  logic            pkt_domain;
  logic            pkt_fail;
  logic [c_mc-1:0] pkt_mem_ctrl;
  logic            unused_net_fields;

  assign pkt_dest          = net_msg_control[c_cn-1 -: c_ns];
  assign pkt_domain        = net_msg_control[c_mc+1];
  assign pkt_fail          = net_msg_control[c_mc];
  assign pkt_mem_ctrl      = net_msg_control[c_mc-1:0];
  // Network src and opaque are not forwarded to the core.
  assign unused_net_fields = ^net_msg_control[c_cn-c_ns-1 -: (c_ns+c_no)];

  // FIFO state
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       domain_q, domain_d;
  logic [1:0][c_mc-1:0]             ctrl_q, ctrl_d;
  logic [1:0][p_mem_data_nbits-1:0] data_q, data_d;
  logic [1:0]                       fail_q, fail_d;

  logic domain_sw, enq, deq, drop, keep;

  // Handshakes, drop decision and next-state for pointers/count/entries
  always_comb begin
    domain_sw    = (domain != domain_q);
    net_rdy      = reset & (count_q != 2'd2) & ~domain_sw;
    // Head is hidden during a switch cycle so old-domain data never leaks out.
    mem_resp_val = reset & (count_q != 2'd0) & ~domain_sw;
    enq          = net_val & net_rdy;
    deq          = mem_resp_val & mem_resp_rdy;
    drop         = enq & ((pkt_dest != c_dest) | (mode & (pkt_domain != domain)));
    keep         = enq & ~drop;

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    domain_d = domain;
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    fail_d   = fail_q;

    if (domain_sw) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (keep) begin
        ctrl_d[wr_ptr_q] = pkt_mem_ctrl;
        data_d[wr_ptr_q] = net_msg_data;
        fail_d[wr_ptr_q] = pkt_fail;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (deq) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, keep} - {1'b0, deq};
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      domain_q <= domain;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      domain_q <= domain_d;
    end
  end

  // Entry storage; validity is tracked entirely by count, so no reset needed
  always_ff @(posedge clk) begin
    ctrl_q <= ctrl_d;
    data_q <= data_d;
    fail_q <= fail_d;
  end

  // Head-entry outputs, forced to zero when empty
  always_comb begin
    mem_resp_control = '0;
    mem_resp_data    = '0;
    mem_resp_fail    = 1'b0;
    if (count_q != 2'd0) begin
      mem_resp_control = ctrl_q[rd_ptr_q];
      mem_resp_data    = data_q[rd_ptr_q];
      mem_resp_fail    = fail_q[rd_ptr_q];
    end
  end

`ifdef PLAB5_MCORE_NET_RESP_VIOL_CNT_EN
  logic [7:0] viol_q, viol_d;

  // Saturating count of consumed-but-dropped packets; flushes never count
  always_comb begin
    viol_d = viol_q;
    if (drop && (viol_q != 8'hFF)) viol_d = viol_q + 8'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!reset) viol_q <= 8'h00;
    else        viol_q <= viol_d;
  end

  assign viol_count = viol_q;
`else
  assign viol_count = 8'h00;
`endif

endmodule

// File: tb/tb_plab5_mcore_net_msg_to_mem_resp.sv
// Randomized + directed bench against a queue-based reference model.
module tb_plab5_mcore_net_msg_to_mem_resp;

  logic        clk;
  logic        reset;
  logic        mode;
  logic        domain;
  logic [24:0] net_msg_control;
  logic [31:0] net_msg_data;
  logic        net_val;
  logic        net_rdy;
  logic [12:0] mem_resp_control;
  logic [31:0] mem_resp_data;
  logic        mem_resp_fail;
  logic        mem_resp_val;
  logic        mem_resp_rdy;
  logic [7:0]  viol_count;

  plab5_mcore_net_msg_to_mem_resp dut (
    .clk(clk), .reset(reset), .mode(mode), .domain(domain),
    .net_msg_control(net_msg_control), .net_msg_data(net_msg_data),
    .net_val(net_val), .net_rdy(net_rdy),
    .mem_resp_control(mem_resp_control), .mem_resp_data(mem_resp_data),
    .mem_resp_fail(mem_resp_fail), .mem_resp_val(mem_resp_val),
    .mem_resp_rdy(mem_resp_rdy), .viol_count(viol_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [12:0] ctrl;
    logic        fail;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  logic m_dom;
  int   m_viol;
  int   n_chk;
  int   n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] mk(input int dest, input int dom, input int fail,
                                     input int typ, input int mop, input int len);
    logic [2:0] d3, t3, s3;
    logic [3:0] n4;
    logic [7:0] m8;
    logic [1:0] l2;
    d3 = dest[2:0]; t3 = typ[2:0]; m8 = mop[7:0]; l2 = len[1:0];
    s3 = 3'($urandom); n4 = 4'($urandom);
    return {d3, s3, n4, dom[0], fail[0], t3, m8, l2};
  endfunction

  function automatic logic exp_rdy();
    return reset && (q.size() < 2) && (domain == m_dom);
  endfunction

  function automatic logic exp_val();
    return reset && (q.size() > 0) && (domain == m_dom);
  endfunction

  function automatic int exp_viol();
`ifdef PLAB5_MCORE_NET_RESP_VIOL_CNT_EN
    return m_viol;
`else
    return 0;
`endif
  endfunction

  // One clock: compare outputs mid-cycle, then advance the model with the edge.
  task automatic step();
    logic [24:0] c;
    logic        rdy, val, drop;
    ent_t        e;
    @(negedge clk);
    rdy = exp_rdy();
    val = exp_val();
    check("net_rdy", 64'(net_rdy), 64'(rdy));
    check("mem_resp_val", 64'(mem_resp_val), 64'(val));
    check("mem_resp_control", 64'(mem_resp_control), q.size() > 0 ? 64'(q[0].ctrl) : 64'd0);
    check("mem_resp_data", 64'(mem_resp_data), q.size() > 0 ? 64'(q[0].data) : 64'd0);
    check("mem_resp_fail", 64'(mem_resp_fail), q.size() > 0 ? 64'(q[0].fail) : 64'd0);
    check("viol_count", 64'(viol_count), 64'(exp_viol()));
    @(posedge clk);
    c = net_msg_control;
    if (!reset) begin
      q.delete(); m_dom = domain; m_viol = 0;
    end else if (domain != m_dom) begin
      q.delete(); m_dom = domain;
    end else begin
      if (val && mem_resp_rdy) void'(q.pop_front());
      if (net_val && rdy) begin
        drop = (c[24:22] != 3'd0) || (mode && (c[14] != domain));
        if (drop) begin
          if (m_viol < 255) m_viol++;
        end else begin
          e.ctrl = c[12:0]; e.fail = c[13]; e.data = net_msg_data;
          q.push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic drain(input int n);
    net_val = 1'b0; mem_resp_rdy = 1'b1;
    for (int i = 0; i < n; i++) step();
    mem_resp_rdy = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; m_dom = 1'b0; m_viol = 0;
    reset = 1'b0; mode = 1'b1; domain = 1'b0; net_val = 1'b0; mem_resp_rdy = 1'b0;
    net_msg_control = '0; net_msg_data = '0;
    @(posedge clk);
    q.delete(); m_dom = domain; m_viol = 0;
    #1;
    step();
    reset = 1'b1;
    step();

    // Basic delivery
    net_msg_control = mk(0, 0, 0, 0, 8'h05, 0);
    net_msg_data = 32'hDEADBEEF; net_val = 1'b1;
    step();
    net_val = 1'b0;
    check("t1_val", 64'(mem_resp_val), 64'd1);
    check("t1_data", 64'(mem_resp_data), 64'hDEADBEEF);
    check("t1_opaque", 64'(mem_resp_control[9:2]), 64'h05);
    drain(2);

    // Fill with consumer stalled; third packet must see net_rdy=0
    for (int i = 0; i < 3; i++) begin
      net_msg_control = mk(0, 0, i & 1, i, 8'h10 + i, i);
      net_msg_data = 32'h1000 + i; net_val = 1'b1;
      step();
    end
    check("t2_full_rdy", 64'(net_rdy), 64'd0);
    net_val = 1'b0; mem_resp_rdy = 1'b1;
    step();
    check("t2_second", 64'(mem_resp_data), 64'h1001);
    drain(3);

    // Cross-domain drop, then bypass with mode=0
    net_msg_control = mk(0, 1, 0, 1, 8'h33, 1); net_msg_data = 32'hA5A5; net_val = 1'b1;
    step();
    net_val = 1'b0;
    check("t3_dropped_val", 64'(mem_resp_val), 64'd0);
    mode = 1'b0; net_val = 1'b1;
    step();
    net_val = 1'b0; mode = 1'b1;
    check("t3_bypass_val", 64'(mem_resp_val), 64'd1);
    drain(2);

    // Misrouted packet
    net_msg_control = mk(2, 0, 0, 0, 8'h44, 0); net_val = 1'b1;
    step();
    net_val = 1'b0;
    check("t4_misroute_val", 64'(mem_resp_val), 64'd0);
    step();

    // Domain switch flushes two buffered entries
    for (int i = 0; i < 2; i++) begin
      net_msg_control = mk(0, 0, 0, 0, i, 0); net_msg_data = 32'h50 + i; net_val = 1'b1;
      step();
    end
    net_val = 1'b0; domain = 1'b1;
    step();
    check("t5_after_flush_val", 64'(mem_resp_val), 64'd0);
    check("t5_after_flush_rdy", 64'(net_rdy), 64'd1);
    check("t5_after_flush_data", 64'(mem_resp_data), 64'd0);
    domain = 1'b0;
    step();
    step();

    // Violation saturation, then reset mid-stream
    net_msg_control = mk(2, 0, 0, 0, 0, 0); net_val = 1'b1;
    for (int i = 0; i < 260; i++) step();
`ifdef PLAB5_MCORE_NET_RESP_VIOL_CNT_EN
    check("t6_saturated", 64'(viol_count), 64'hFF);
`else
    check("t6_no_counter", 64'(viol_count), 64'h00);
`endif
    reset = 1'b0;
    step();
    reset = 1'b1; net_val = 1'b0;
    check("t6_reset_viol", 64'(viol_count), 64'h00);
    check("t6_reset_val", 64'(mem_resp_val), 64'd0);
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      net_val      = 1'($urandom);
      mem_resp_rdy = ($urandom % 3) != 0;
      mode         = ($urandom % 4) != 0;
      if (($urandom % 40) == 0) domain = ~domain;
      reset        = ($urandom % 150) != 0;
      net_msg_control = mk((($urandom % 4) == 0) ? int'($urandom % 8) : 0,
                           (($urandom % 4) == 0) ? int'(~domain) : int'(domain),
                           int'($urandom % 2), int'($urandom % 8),
                           int'($urandom % 256), int'($urandom % 4));
      net_msg_data = $urandom;
      step();
    end
    reset = 1'b1; net_val = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
